// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN MSB first, REP times,
// with GAP zero-bits between repeats; flags the last bit of each repeat.
module seq_pattern_gen #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [CNT_W-1:0] gap_cnt,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             expected_hit,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [CNT_W-1:0] rep, rep_d;
  logic [CNT_W-1:0] gap_len, gap_len_d;
  logic [CNT_W-1:0] gap_left, gap_left_d;
  logic [PAT_W-1:0] pat_rev;

  logic bit_out_d, bit_valid_d, hit_d, busy_d, done_d;

  // Reversed copy so the current bit index selects directly.
  always_comb begin
    for (int i = 0; i < PAT_W; i++) begin
      pat_rev[i] = PATTERN[PAT_W-1-i];
    end
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    rep_d      = rep;
    gap_len_d  = gap_len;
    gap_left_d = gap_left;
    if (abort && state != IDLE) begin
      state_d    = IDLE;
      idx_d      = '0;
      rep_d      = '0;
      gap_len_d  = '0;
      gap_left_d = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            rep_d     = rep_cnt;
            gap_len_d = gap_cnt;
            idx_d     = '0;
            state_d   = (rep_cnt == '0) ? DONE : SEND;
          end
        end
        SEND: begin
          if (idx == LAST) begin
            idx_d = '0;
            rep_d = (rep != '0) ? rep - 1'b1 : '0;
            if (rep_d == '0) begin
              state_d = DONE;
            end else if (gap_len != '0) begin
              state_d    = GAP;
              gap_left_d = gap_len;
            end else begin
              state_d = SEND;
            end
          end else begin
            idx_d = idx + 1'b1;
          end
        end
        GAP: begin
          if (gap_left <= 1) begin
            state_d    = SEND;
            gap_left_d = '0;
          end else begin
            gap_left_d = gap_left - 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from next state so they leave flops aligned with it.
  always_comb begin
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    hit_d       = 1'b0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    if (state_d == SEND) begin
      bit_out_d   = pat_rev[idx_d];
      bit_valid_d = 1'b1;
      hit_d       = (idx_d == LAST);
    end else if (state_d == GAP) begin
      bit_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      rep          <= '0;
      gap_len      <= '0;
      gap_left     <= '0;
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
      expected_hit <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      rep          <= rep_d;
      gap_len      <= gap_len_d;
      gap_left     <= gap_left_d;
      bit_out      <= bit_out_d;
      bit_valid    <= bit_valid_d;
      expected_hit <= hit_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: per-cycle expected-output queue built
// from the stream rules, driven by directed and random stimulus.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] rep_cnt;
  logic [7:0] gap_cnt;
  logic       bit_out;
  logic       bit_valid;
  logic       expected_hit;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fails  = 0;

  // {bit_out, bit_valid, expected_hit, busy, done}
  logic [4:0] q[$];
  logic [3:0] pat = 4'b1101;

  always #5 clk = ~clk;

  seq_pattern_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .rep_cnt      (rep_cnt),
    .gap_cnt      (gap_cnt),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .expected_hit (expected_hit),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [4:0] got,
                       input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  task automatic push_seq(input int r, input int g);
    for (int k = 0; k < r; k++) begin
      for (int b = 0; b < 4; b++) begin
        q.push_back({pat[3-b], 1'b1, (b == 3), 1'b1, 1'b0});
      end
      if (k < r - 1) begin
        for (int j = 0; j < g; j++) q.push_back(5'b01010);
      end
    end
    q.push_back(5'b00011);
  endtask

  task automatic step(input logic s, input logic a, input logic [7:0] r,
                      input logic [7:0] g, input string tag);
    logic [4:0] cur;
    logic       was_busy;
    @(negedge clk);
    cur = (q.size() != 0) ? q[0] : 5'b0;
    check(tag, {bit_out, bit_valid, expected_hit, busy, done}, cur);
    was_busy = (q.size() != 0);
    start   = s;
    abort   = a;
    rep_cnt = r;
    gap_cnt = g;
    if (was_busy) void'(q.pop_front());
    if (was_busy && a) q.delete();
    else if (!was_busy && s && !a) push_seq(int'(r), int'(g));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 8'd0, tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    rep_cnt = '0; gap_cnt = '0;
    #1;
    check("reset", {bit_out, bit_valid, expected_hit, busy, done}, 5'b0);
    #20;
    @(negedge clk);
    rst = 1'b0;
    idle(2, "post_reset");

    step(1'b1, 1'b0, 8'd1, 8'd0, "t1_single");
    idle(7, "t1_single");

    step(1'b1, 1'b0, 8'd3, 8'd2, "t2_gap");
    idle(19, "t2_gap");

    step(1'b1, 1'b0, 8'd2, 8'd0, "t3_nogap");
    idle(11, "t3_nogap");

    step(1'b1, 1'b0, 8'd0, 8'd5, "t4_zero");
    idle(4, "t4_zero");

    step(1'b1, 1'b0, 8'd4, 8'd1, "t5_abort");
    idle(5, "t5_abort");
    step(1'b1, 1'b1, 8'd4, 8'd1, "t5_abort");
    idle(1, "t5_abort");
    step(1'b1, 1'b0, 8'd1, 8'd0, "t5_restart");
    idle(7, "t5_restart");

    step(1'b1, 1'b0, 8'd3, 8'd3, "t6_rst");
    idle(5, "t6_rst");
    #2 rst = 1'b1;
    #1;
    check("t6_rst_async", {bit_out, bit_valid, expected_hit, busy, done},
          5'b0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'd0, 8'd0, "t6_done_start");
    step(1'b1, 1'b0, 8'd1, 8'd0, "t6_done_start");
    step(1'b1, 1'b0, 8'd1, 8'd0, "t6_done_start");
    idle(7, "t6_done_start");

    step(1'b1, 1'b0, 8'd255, 8'd1, "max_rep");
    for (int i = 0; i < 2000 && q.size() != 0; i++) begin
      step(1'b0, 1'b0, 8'($urandom), 8'($urandom), "max_rep");
    end
    check("max_rep_drained", 5'(q.size() != 0), 5'b0);
    idle(2, "max_rep");

    for (int i = 0; i < 4000; i++) begin
      logic s, a;
      s = ($urandom_range(0, 3) == 0);
      a = (q.size() != 0) && ($urandom_range(0, 39) == 0);
      step(s, a, 8'($urandom_range(0, 5)), 8'($urandom_range(0, 3)),
           "random");
    end
    for (int i = 0; i < 100 && q.size() != 0; i++) idle(1, "drain");
    idle(2, "final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
